// File: rtl/simon_sequencer.sv
// Simon memory game sequencer: fills a random color sequence from a free-running
// LFSR, plays it back with timed lit/dark phases and checks the player's key presses.
module simon_sequencer #(
  parameter int          MAX_LEN  = 16,
  parameter int          SHOW_CYC = 25000000,
  parameter int          GAP_CYC  = 12500000,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] level,
  input  logic [3:0] key_pulse,
  output logic [3:0] show_color,
  output logic [1:0] state,
  output logic [3:0] round,
  output logic       win,
  output logic       lose
);

  localparam int IDX_W     = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam int XW        = ((IDX_W > 4) ? IDX_W : 4) + 1;
  localparam int DWELL_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int CNT_W     = $clog2(DWELL_MAX + 1);

  localparam logic [IDX_W-1:0] GEN_LAST  = IDX_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, GEN, SHOW_ON, SHOW_GAP, USER, WIN, LOSE
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  function automatic logic [3:0] level_target(input logic [2:0] l);
    case (l)
      3'd2:    return 4'd6;
      3'd3:    return 4'd9;
      3'd4:    return 4'd12;
      3'd5:    return 4'd15;
      default: return 4'd3;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  state_t           st, st_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [3:0]       round_nxt;
  logic [3:0]       target, target_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lead, lead_nxt;
  logic [15:0]      lfsr;
  logic [1:0]       seq [MAX_LEN];
  logic [1:0]       cur;
  logic [XW-1:0]    idx_inc;
  logic             seq_we;

  assign cur     = seq[idx];
  assign idx_inc = XW'(idx) + XW'(1);

  always_comb begin
    st_nxt     = st;
    idx_nxt    = idx;
    round_nxt  = round;
    target_nxt = target;
    cnt_nxt    = cnt;
    lead_nxt   = lead;
    seq_we     = 1'b0;
    case (st)
      IDLE, WIN, LOSE: begin
        if (start) begin
          st_nxt     = GEN;
          target_nxt = level_target(level);
          idx_nxt    = '0;
          round_nxt  = '0;
          cnt_nxt    = '0;
          lead_nxt   = 1'b0;
        end
      end
      GEN: begin
        seq_we = 1'b1;
        if (idx == GEN_LAST) begin
          st_nxt    = SHOW_ON;
          idx_nxt   = '0;
          round_nxt = 4'd1;
          cnt_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      SHOW_ON: begin
        if (cnt == SHOW_LAST) begin
          st_nxt  = SHOW_GAP;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SHOW_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          // A leading pause before a replay restarts playback at entry 0.
          if (lead) begin
            lead_nxt = 1'b0;
            st_nxt   = SHOW_ON;
          end else if (idx_inc == XW'(round)) begin
            st_nxt  = USER;
            idx_nxt = '0;
          end else begin
            st_nxt  = SHOW_ON;
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      USER: begin
        if (key_pulse != 4'd0) begin
          if (key_pulse == onehot4(cur)) begin
            if (idx_inc == XW'(round)) begin
              if (round == target) begin
                st_nxt = WIN;
              end else begin
                st_nxt    = SHOW_GAP;
                round_nxt = round + 4'd1;
                idx_nxt   = '0;
                cnt_nxt   = '0;
                lead_nxt  = 1'b1;
              end
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            st_nxt = LOSE;
          end
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st     <= IDLE;
      idx    <= '0;
      round  <= '0;
      target <= 4'd3;
      cnt    <= '0;
      lead   <= 1'b0;
      lfsr   <= SEED;
    end else begin
      st     <= st_nxt;
      idx    <= idx_nxt;
      round  <= round_nxt;
      target <= target_nxt;
      cnt    <= cnt_nxt;
      lead   <= lead_nxt;
      lfsr   <= lfsr_step(lfsr);
    end
  end

  // Sequence memory holds data only; it is deliberately left out of reset.
  always_ff @(posedge CLOCK_50) begin
    if (seq_we) seq[idx] <= lfsr[1:0];
  end

  always_comb begin
    show_color = (st == SHOW_ON) ? onehot4(cur) : 4'd0;
    win        = (st == WIN);
    lose       = (st == LOSE);
    case (st)
      IDLE:                   state = 2'b00;
      GEN, SHOW_ON, SHOW_GAP: state = 2'b01;
      USER:                   state = 2'b10;
      default:                state = 2'b11;
    endcase
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Scoreboard bench for simon_sequencer: expected playback colors are queued when a
// round is launched and popped as each lit color appears on show_color.
module tb_simon_sequencer;

  localparam int          MAX_LEN  = 16;
  localparam int          SHOW_CYC = 2;
  localparam int          GAP_CYC  = 1;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic       CLOCK_50;
  logic       reset;
  logic       start;
  logic [2:0] level;
  logic [3:0] key_pulse;
  logic [3:0] show_color;
  logic [1:0] state;
  logic [3:0] round;
  logic       win;
  logic       lose;

  simon_sequencer #(
    .MAX_LEN (MAX_LEN),
    .SHOW_CYC(SHOW_CYC),
    .GAP_CYC (GAP_CYC),
    .SEED    (SEED)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .level     (level),
    .key_pulse (key_pulse),
    .show_color(show_color),
    .state     (state),
    .round     (round),
    .win       (win),
    .lose      (lose)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q [$];
  logic [1:0] exp_seq [MAX_LEN];
  logic [15:0] m_lfsr;

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  // Reference LFSR advancing on the same edges as the design.
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  logic [3:0] prev_show = 4'd0;
  int         lit_len   = 0;

  always @(negedge CLOCK_50) begin
    if (reset) begin
      lit_len   = 0;
      prev_show = 4'd0;
    end else begin
      if (show_color != 4'd0) begin
        if (prev_show == 4'd0) begin
          if (exp_q.size() == 0) chk("show_unexpected", show_color, 0);
          else                   chk("show_color", show_color, exp_q.pop_front());
        end
        lit_len++;
      end else if (prev_show != 4'd0) begin
        chk("show_len", lit_len, SHOW_CYC);
        lit_len = 0;
      end
      prev_show = show_color;
    end
  end

  task automatic cyc();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic start_game(input logic [2:0] lvl, input bit with_key);
    level     = lvl;
    start     = 1'b1;
    key_pulse = with_key ? 4'b0001 : 4'b0000;
    cyc();
    start     = 1'b0;
    key_pulse = 4'b0000;
    chk("gen_win_clr", win, 0);
    chk("gen_lose_clr", lose, 0);
    for (int k = 0; k < MAX_LEN; k++) begin
      chk("gen_state", state, 1);
      exp_seq[k] = m_lfsr[1:0];
      if (k == 0) exp_q.push_back(onehot(exp_seq[0]));
      cyc();
    end
    chk("first_lit_a", show_color, onehot(exp_seq[0]));
    chk("first_state", state, 1);
    chk("first_round", round, 1);
    cyc();
    chk("first_lit_b", show_color, onehot(exp_seq[0]));
    cyc();
    chk("first_gap_dark", show_color, 0);
    chk("first_gap_state", state, 1);
    cyc();
    chk("first_user", state, 2);
    chk("first_drain", exp_q.size(), 0);
  endtask

  task automatic wait_user(input int r);
    int budget;
    budget = r * (SHOW_CYC + GAP_CYC) + GAP_CYC + 6;
    while (state != 2'b10 && budget > 0) begin
      cyc();
      budget--;
    end
    chk("reach_user", state, 2);
    chk("user_round", round, r);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic enter_round(input int r);
    for (int i = 0; i < r; i++) begin
      key_pulse = onehot(exp_seq[i]);
      cyc();
      key_pulse = 4'b0000;
      if (i < r - 1) begin
        chk("key_mid", state, 2);
        cyc();
        chk("idle_key_cycle", state, 2);
      end
    end
  endtask

  task automatic play_game(input logic [2:0] lvl, input int tgt, input bit with_key,
                           input bit poke);
    start_game(lvl, with_key);
    if (poke) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("start_in_user_state", state, 2);
      chk("start_in_user_round", round, 1);
    end
    for (int r = 1; r <= tgt; r++) begin
      if (r > 1) begin
        for (int i = 0; i < r; i++) exp_q.push_back(onehot(exp_seq[i]));
        if (poke && r == 2) begin
          cyc();
          chk("poke_show_on", state, 1);
          key_pulse = 4'b1111;
          cyc();
          key_pulse = 4'b0000;
          chk("key_ignored_state", state, 1);
          chk("key_ignored_round", round, 2);
        end
        wait_user(r);
      end
      enter_round(r);
      if (r < tgt) begin
        chk("replay_state", state, 1);
        chk("replay_round", round, r + 1);
        chk("replay_dark", show_color, 0);
      end
    end
    chk("win_state", state, 3);
    chk("win_flag", win, 1);
    chk("win_lose_flag", lose, 0);
    cyc();
    chk("win_hold", win, 1);
  endtask

  task automatic lose_game(input logic [2:0] lvl, input bit multi);
    start_game(lvl, 1'b0);
    key_pulse = multi ? 4'b0011 : onehot(exp_seq[0] + 2'd1);
    cyc();
    key_pulse = 4'b0000;
    chk("lose_state", state, 3);
    chk("lose_flag", lose, 1);
    chk("lose_win_flag", win, 0);
    cyc();
    chk("lose_hold", lose, 1);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    level     = 3'd1;
    key_pulse = 4'b0000;
    #2 reset = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_show", show_color, 0);
    chk("rst_round", round, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    cyc();
    chk("idle_state", state, 0);

    play_game(3'd1, 3, 1'b0, 1'b1);
    play_game(3'd0, 3, 1'b1, 1'b0);
    play_game(3'd7, 3, 1'b0, 1'b0);
    play_game(3'd5, 15, 1'b0, 1'b0);
    lose_game(3'd1, 1'b0);
    lose_game(3'd1, 1'b1);

    // Abort in the middle of round-2 playback.
    start_game(3'd1, 1'b0);
    enter_round(1);
    for (int i = 0; i < 2; i++) exp_q.push_back(onehot(exp_seq[i]));
    cyc();
    chk("abort_lit", show_color, onehot(exp_seq[0]));
    chk("abort_round", round, 2);
    #1 reset = 1'b1;
    #1;
    chk("abort_state", state, 0);
    chk("abort_show", show_color, 0);
    chk("abort_round_clr", round, 0);
    chk("abort_win", win, 0);
    chk("abort_lose", lose, 0);
    exp_q.delete();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    cyc();
    start_game(3'd1, 1'b0);
    chk("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 The module SHALL have parameter MAX_LEN, default 16, giving sequence memory depth in entries.
REQ-002 The module SHALL have parameter SHOW_CYC, default 25000000, giving clock cycles a color is lit during playback.
REQ-003 The module SHALL have parameter GAP_CYC, default 12500000, giving dark clock cycles after each lit color.
REQ-004 The module SHALL have parameter SEED, default 16'hACE1, giving the LFSR reset value (nonzero).
REQ-005 The module SHALL have port CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port start, input, 1 bit: single-cycle request to begin a new game.
REQ-008 The module SHALL have port level, input, 3 bits: difficulty 1..5; 0, 6 and 7 are treated as 1.
REQ-009 The module SHALL have port key_pulse, input, 4 bits: debounced single-cycle press per color, bit i = color i.
REQ-010 The module SHALL have port show_color, output, 4 bits: one-hot lit color, 0 = dark.
REQ-011 The module SHALL have port state, output, 2 bits: 00 idle, 01 game playback, 10 user input, 11 finished.
REQ-012 The module SHALL have port round, output, 4 bits: current sequence length being played/entered.
REQ-013 The module SHALL have ports win and lose, outputs, 1 bit each: game result flags.

Function
REQ-014 The module SHALL implement FSM states IDLE, GEN, SHOW_ON, SHOW_GAP, USER, WIN, LOSE.
REQ-015 The state output SHALL be 00 in IDLE; 01 in GEN, SHOW_ON and SHOW_GAP; 10 in USER; 11 in WIN and LOSE.
REQ-016 The module SHALL free-run a 16-bit Galois LFSR (mask 16'hB400) every cycle in every state.
REQ-017 On start in IDLE, WIN or LOSE, the module SHALL latch target = 3*level (normalised level), clear win/lose, and enter GEN next cycle.
REQ-018 GEN SHALL last exactly MAX_LEN cycles, writing LFSR[1:0] into entry k on the k-th cycle, then enter SHOW_ON with round=1, idx=0.
REQ-019 SHOW_ON SHALL drive show_color = one-hot of seq[idx] for exactly SHOW_CYC cycles, then enter SHOW_GAP.
REQ-020 SHOW_GAP SHALL drive show_color = 0 for exactly GAP_CYC cycles, then increment idx; if idx reaches round, enter USER with idx=0, else SHOW_ON.
REQ-021 In USER, show_color SHALL be 0; a cycle with key_pulse==0 SHALL change nothing.
REQ-022 In USER, a one-hot key_pulse matching seq[idx] SHALL increment idx; when this completes entry round-1, the module SHALL enter WIN if round==target, else increment round, set idx=0 and enter SHOW_GAP (dark pause before replay).
REQ-023 In USER, a mismatching or multi-hot key_pulse SHALL enter LOSE in the next cycle.
REQ-024 win SHALL be 1 only in WIN; lose SHALL be 1 only in LOSE; both hold until start or reset.
REQ-025 start SHALL be ignored in GEN, SHOW_ON, SHOW_GAP and USER; key_pulse SHALL be ignored outside USER.
REQ-026 If start and key_pulse are asserted together in WIN or LOSE, start SHALL take effect and key_pulse SHALL be ignored.
REQ-027 Dwell counters SHALL be wide enough for SHOW_CYC and GAP_CYC without wrap; round never exceeds target (max 15 < MAX_LEN).

Reset
REQ-028 While reset is high, the module SHALL force IDLE, show_color=0, state=00, round=0, win=0, lose=0, idx=0, LFSR=SEED, independent of the clock.
REQ-029 Reset asserted mid-game (any state) SHALL abort immediately to IDLE; sequence memory contents need not be cleared.

Verification (SHOW_CYC=2, GAP_CYC=1, MAX_LEN=16)
REQ-030 Reset, start with level=1 -> state 01 for 16 GEN cycles, then show_color lit 2 cycles / dark 1 cycle, round=1, then state 10.
REQ-031 Level=1, enter all correct keys each round -> rounds 1,2,3 replayed with growing length; after round 3 completes, state=11, win=1, lose=0.
REQ-032 In USER round 1, press a wrong color -> next cycle state=11, lose=1, win=0; key_pulse=4'b0011 gives same result.
REQ-033 level=0 and level=7 -> target=3 (same as level 1); level=5 -> target=15, win only after round 15.
REQ-034 Assert reset during SHOW_ON of round 2 -> outputs go to reset values without a clock edge; start then reruns GEN.
REQ-035 key_pulse during SHOW_ON and start during USER -> no state, idx or round change.
